// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with power-of-2 depth, optional first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, fill level and sticky error flags.
module fifo_sync_flags #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 14,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow,
  input  logic                       clr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic             overflow_reg;
  logic             underflow_reg;
  logic             rd_acc;
  logic             wr_acc;

  // A write while full only goes through when a pop frees the slot in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign full         = (level_reg == DEPTH_LVL);
  assign empty        = (level_reg == '0);
  assign almost_full  = (level_reg >= AF_LVL);
  assign almost_empty = (level_reg <= AE_LVL);
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  // Storage has no reset so it maps onto block or distributed RAM.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      // A fresh error in the clear cycle keeps the flag set.
      overflow_reg  <= (overflow_reg & ~clr_err) | (wr_en & ~wr_acc);
      underflow_reg <= (underflow_reg & ~clr_err) | (rd_en & empty);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = empty ? '0 : mem[rd_ptr_reg];
    end else begin : g_std
      logic [WIDTH-1:0] dout_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          dout_reg <= '0;
        end else if (rd_acc) begin
          dout_reg <= mem[rd_ptr_reg];
        end
      end
      assign dout = dout_reg;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_flags.sv
// Directed bench: a standard-read and a FWFT instance share one stimulus stream;
// a vector table covers fill/drain, hand sequences cover the multi-cycle corners.
module tb_fifo_sync_flags;

  logic       clk = 1'b0;
  logic       rst, wr_en, rd_en, clr_err;
  logic [7:0] din;
  logic [7:0] dout0, dout1;
  logic       full0, empty0, af0, ae0, ovf0, unf0;
  logic       full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0] level0, level1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sync_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .level(level0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
  );

  fifo_sync_flags #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .level(level1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
  );

  typedef struct {
    logic       rs, wr, rd, clr;
    logic [7:0] din;
    logic [7:0] exp_dout;
    logic [7:0] exp_fdout;
    logic [4:0] exp_level;
    logic [5:0] exp_flags;
  } vec_t;

  vec_t tbl[$];

  // {full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [5:0] exp_fl(int lv, bit o, bit u);
    return {lv == 16, lv == 0, lv >= 14, lv <= 2, o, u};
  endfunction

  function automatic vec_t mk(bit rs, bit wr, bit rd, bit clr, logic [7:0] d,
                              logic [7:0] ed, logic [7:0] efd, int lv, bit o, bit u);
    vec_t v;
    v.rs = rs; v.wr = wr; v.rd = rd; v.clr = clr; v.din = d;
    v.exp_dout = ed; v.exp_fdout = efd; v.exp_level = 5'(lv);
    v.exp_flags = exp_fl(lv, o, u);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply(input logic w, input logic [7:0] d, input logic r,
                       input logic c, input logic s);
    wr_en = w; din = d; rd_en = r; clr_err = c; rst = s;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;

    // Test 1/2: reset, fill 0x00..0x0F, rejected 17th write, drain, extra read.
    tbl.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(0, 1, 0, 0, 8'(i), 8'h00, 8'h00, i + 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 8'h10, 8'h00, 8'h00, 16, 1, 0));
    for (int j = 0; j < 16; j++)
      tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'(j), (j < 15) ? 8'(j + 1) : 8'h00, 15 - j, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 8'h00, 8'h0F, 8'h00, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 8'h00, 8'h0F, 8'h00, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      apply(tbl[k].wr, tbl[k].din, tbl[k].rd, tbl[k].clr, tbl[k].rs);
      check($sformatf("vec%0d dout", k), dout0, tbl[k].exp_dout);
      check($sformatf("vec%0d fwft_dout", k), dout1, tbl[k].exp_fdout);
      check($sformatf("vec%0d level", k), level0, tbl[k].exp_level);
      check($sformatf("vec%0d flags", k), {full0, empty0, af0, ae0, ovf0, unf0}, tbl[k].exp_flags);
      check($sformatf("vec%0d fwft_flags", k), {full1, empty1, af1, ae1, ovf1, unf1}, tbl[k].exp_flags);
      check($sformatf("vec%0d fwft_level", k), level1, tbl[k].exp_level);
      $display("vec %0d rst=%0b wr=%0b rd=%0b din=%02h -> dout=%02h fdout=%02h level=%0d",
               k, tbl[k].rs, tbl[k].wr, tbl[k].rd, tbl[k].din, dout0, dout1, level0);
    end

    // Test 3: hold level 5 with simultaneous read/write across pointer wrap.
    apply(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) apply(1, 8'(8'h20 + i), 0, 0, 0);
    for (int c = 0; c < 40; c++) begin
      apply(1, 8'(8'h25 + c), 1, 0, 0);
      check($sformatf("hold c%0d dout", c), dout0, 8'h20 + c);
      check($sformatf("hold c%0d fwft_dout", c), dout1, 8'h21 + c);
      check($sformatf("hold c%0d level", c), level0, 5);
      $display("hold %0d dout=%02h fdout=%02h level=%0d", c, dout0, dout1, level0);
    end
    for (int r = 0; r < 5; r++) begin
      apply(0, 0, 1, 0, 0);
      check($sformatf("hold drain%0d", r), dout0, 8'h48 + r);
    end
    check("hold empty", empty0, 1);
    check("hold no errors", {ovf0, unf0}, 0);

    // Test 4: write with pop while full.
    apply(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) apply(1, 8'(8'h40 + i), 0, 0, 0);
    check("full before", full0, 1);
    apply(1, 8'hEE, 1, 0, 0);
    $display("full wr+rd dout=%02h level=%0d ovf=%0b", dout0, level0, ovf0);
    check("fullwr dout", dout0, 8'h40);
    check("fullwr level", level0, 16);
    check("fullwr overflow", ovf0, 0);
    for (int r = 0; r < 16; r++) begin
      apply(0, 0, 1, 0, 0);
      check($sformatf("fullwr drain%0d", r), dout0, (r < 15) ? 8'h41 + r : 8'hEE);
    end
    check("fullwr empty", empty0, 1);

    // Test 5: FWFT head visibility, then empty with write+read.
    apply(0, 0, 0, 0, 1);
    apply(1, 8'hA5, 0, 0, 0);
    $display("fwft write A5 empty=%0b dout=%02h", empty1, dout1);
    check("fwft empty after wr", empty1, 0);
    check("fwft dout after wr", dout1, 8'hA5);
    check("std dout no read", dout0, 8'h00);
    apply(0, 0, 1, 0, 0);
    check("fwft empty after rd", empty1, 1);
    check("fwft dout after rd", dout1, 8'h00);
    check("std dout after rd", dout0, 8'hA5);
    apply(1, 8'h77, 1, 0, 0);
    $display("empty wr+rd level=%0d unf=%0b dout=%02h fdout=%02h", level0, unf0, dout0, dout1);
    check("emptywr level", level0, 1);
    check("emptywr underflow", unf0, 1);
    check("emptywr dout hold", dout0, 8'hA5);
    check("emptywr fwft dout", dout1, 8'h77);
    apply(0, 0, 0, 1, 0);
    check("clr underflow", unf0, 0);
    check("clr keeps level", level0, 1);

    // Test 6: reset mid-operation, then clear colliding with a new overflow.
    apply(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) apply(1, 8'(i), 0, 0, 0);
    apply(1, 8'h99, 0, 0, 0);
    for (int r = 0; r < 7; r++) apply(0, 0, 1, 0, 0);
    check("pre-rst level", level0, 9);
    check("pre-rst overflow", ovf0, 1);
    check("pre-rst dout", dout0, 8'h06);
    apply(1, 8'h55, 1, 0, 1);
    $display("rst mid-op level=%0d empty=%0b ovf=%0b dout=%02h", level0, empty0, ovf0, dout0);
    check("rst level", level0, 0);
    check("rst empty", empty0, 1);
    check("rst overflow", ovf0, 0);
    check("rst dout", dout0, 8'h00);
    for (int i = 0; i < 16; i++) apply(1, 8'(i), 0, 0, 0);
    apply(1, 8'h99, 0, 1, 0);
    check("clr with new overflow", ovf0, 1);
    apply(0, 0, 0, 1, 0);
    check("clr overflow", ovf0, 0);
    check("clr level kept", level0, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
